gate_ctrl: RTL and testbench

GATE_CTRL -- requirements
Module: gate_ctrl

---
 rtl/gate_ctrl_if.sv | 21 ++
 rtl/gate_ctrl.sv | 111 +++++++++++
 tb/tb_gate_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_ctrl_if.sv
// gate_ctrl_if: start/timebase/signal inputs and measurement results of gate_ctrl.
interface gate_ctrl_if;
    logic        gate_st_i;
    logic [7:0]  gate_time_i;
    logic        tick_i;
    logic        sig_i;
    logic        gate_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] ref_cnt_o;
    logic [31:0] sig_cnt_o;
    modport master (
        output gate_st_i, gate_time_i, tick_i, sig_i,
        input  gate_o, busy_o, done_o, err_o, ref_cnt_o, sig_cnt_o
    );
    modport slave (
        input  gate_st_i, gate_time_i, tick_i, sig_i,
        output gate_o, busy_o, done_o, err_o, ref_cnt_o, sig_cnt_o
    );
endinterface

// File: rtl/gate_ctrl.sv
// gate_ctrl: gated counter; the window opens on a signal rise, lasts gt ticks,
// then closes on the next rise, counting clock cycles and rises inside it.
module gate_ctrl (
    input  logic       clk_i,
    input  logic       rst_i,
    gate_ctrl_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_ARM, S_GATE, S_CLOSE, S_DONE} state_t;
    state_t      r_state;
    state_t      w_next;
    logic        r_sig_q;
    logic        r_gate;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [7:0]  r_gt;
    logic [7:0]  r_tick_cnt;
    logic [31:0] r_ref_cnt;
    logic [31:0] r_sig_cnt;
    logic [7:0]  w_tick_nxt;
    logic        w_rise;
    logic        w_start;
    logic        w_tick_hit;
    logic        w_tick_clr;
    logic        w_err_set;
    logic        w_counting;

    assign w_rise     = bus.sig_i & ~r_sig_q;
    assign w_start    = (r_state == S_IDLE) & bus.gate_st_i & (bus.gate_time_i != 8'd0);
    assign w_tick_nxt = r_tick_cnt + 8'd1;
    assign w_tick_hit = bus.tick_i & (w_tick_nxt == r_gt);
    assign w_counting = (r_state == S_ARM) | (r_state == S_GATE) | (r_state == S_CLOSE);

    // A rise wins over a terminal tick in ARM and CLOSE; in GATE both act.
    always_comb begin
        w_next     = r_state;
        w_tick_clr = 1'b0;
        w_err_set  = 1'b0;
        case (r_state)
            S_IDLE:  w_next = w_start ? S_ARM : S_IDLE;
            S_ARM: begin
                if (w_rise) begin
                    w_next     = S_GATE;
                    w_tick_clr = 1'b1;
                end else if (w_tick_hit) begin
                    w_next    = S_DONE;
                    w_err_set = 1'b1;
                end
            end
            S_GATE: begin
                if (w_tick_hit) begin
                    w_next     = S_CLOSE;
                    w_tick_clr = 1'b1;
                end
            end
            S_CLOSE: begin
                if (w_rise) begin
                    w_next = S_DONE;
                end else if (w_tick_hit) begin
                    w_next    = S_DONE;
                    w_err_set = 1'b1;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_sig_q    <= 1'b0;
            r_gate     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_gt       <= 8'd0;
            r_tick_cnt <= 8'd0;
            r_ref_cnt  <= 32'd0;
            r_sig_cnt  <= 32'd0;
        end else begin
            r_state <= w_next;
            r_sig_q <= bus.sig_i;
            r_gate  <= (w_next == S_GATE) || (w_next == S_CLOSE);
            r_busy  <= w_next != S_IDLE;
            r_done  <= w_next == S_DONE;
            r_err   <= w_start ? 1'b0 : (r_err | w_err_set);
            if (w_start)
                r_gt <= bus.gate_time_i;
            if (w_start || w_tick_clr)
                r_tick_cnt <= 8'd0;
            else if (bus.tick_i && w_counting)
                r_tick_cnt <= w_tick_nxt;
            if (w_start)
                r_ref_cnt <= 32'd0;
            else if (r_gate && !(&r_ref_cnt))
                r_ref_cnt <= r_ref_cnt + 32'd1;
            if (w_start)
                r_sig_cnt <= 32'd0;
            else if (r_gate && w_rise && !(&r_sig_cnt))
                r_sig_cnt <= r_sig_cnt + 32'd1;
        end
    end

    assign bus.gate_o    = r_gate;
    assign bus.busy_o    = r_busy;
    assign bus.done_o    = r_done;
    assign bus.err_o     = r_err;
    assign bus.ref_cnt_o = r_ref_cnt;
    assign bus.sig_cnt_o = r_sig_cnt;
endmodule

// File: tb/tb_gate_ctrl.sv
// tb_gate_ctrl: directed and randomized checks of gate_ctrl against a window-scan
// reference model that predicts each measurement from the recorded stimulus.
module tb_gate_ctrl;
    localparam int NMAX = 512;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    gate_ctrl_if bus ();
    gate_ctrl dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    always #5 clk_i = ~clk_i;

    bit          sig_a  [NMAX];
    bit          tick_a [NMAX];
    bit          st_a   [NMAX];
    logic [7:0]  gtx_a  [NMAX];
    logic        ob_gate [NMAX];
    logic        ob_busy [NMAX];
    logic        ob_done [NMAX];
    logic        ob_err  [NMAX];
    logic [31:0] ob_ref  [NMAX];
    logic [31:0] ob_sig  [NMAX];

    task automatic clear_stim();
        for (int k = 0; k < NMAX; k++) begin
            sig_a[k]  = 1'b0;
            tick_a[k] = 1'b0;
            st_a[k]   = 1'b0;
            gtx_a[k]  = 8'd0;
        end
    endtask

    // One idle cycle, then the start pulse at index 0 and the stimulus arrays.
    task automatic run_cycles(input logic [7:0] gt, input int n);
        bus.gate_st_i = 1'b0;
        bus.gate_time_i = 8'd0;
        bus.sig_i = 1'b0;
        bus.tick_i = 1'b0;
        @(posedge clk_i); #1;
        for (int k = 0; k < n; k++) begin
            bus.gate_st_i   = (k == 0) || st_a[k];
            bus.gate_time_i = (k == 0) ? gt : gtx_a[k];
            bus.sig_i       = sig_a[k];
            bus.tick_i      = tick_a[k];
            @(posedge clk_i); #1;
            ob_gate[k] = bus.gate_o;
            ob_busy[k] = bus.busy_o;
            ob_done[k] = bus.done_o;
            ob_err[k]  = bus.err_o;
            ob_ref[k]  = bus.ref_cnt_o;
            ob_sig[k]  = bus.sig_cnt_o;
        end
        bus.gate_st_i = 1'b0;
        bus.tick_i = 1'b0;
    endtask

    function automatic bit rise_at(input int k);
        return (k > 0) && sig_a[k] && !sig_a[k-1];
    endfunction

    // Predict open edge gs, completion edge dk, error flag and both counts.
    task automatic model(input int gt, input int lim, output int gs, output int dk,
                         output bit err, output int rc, output int sc);
        int t;
        bit closing;
        t = 0; closing = 0; gs = -1; dk = -1; err = 0; rc = 0; sc = 0;
        for (int k = 1; k < lim && gs < 0 && dk < 0; k++) begin
            if (rise_at(k)) gs = k;
            else if (tick_a[k]) begin
                t++;
                if (t == gt) begin err = 1; dk = k; end
            end
        end
        if (gs >= 0) begin
            t = 0;
            for (int k = gs + 1; k < lim && dk < 0; k++) begin
                rc++;
                if (rise_at(k)) sc++;
                if (!closing) begin
                    if (tick_a[k]) begin
                        t++;
                        if (t == gt) begin closing = 1; t = 0; end
                    end
                end else if (rise_at(k)) dk = k;
                else if (tick_a[k]) begin
                    t++;
                    if (t == gt) begin err = 1; dk = k; end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        bus.sig_i = 1'b1;
        bus.tick_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        n_tests++;
        if ({bus.gate_o, bus.busy_o, bus.done_o, bus.err_o, bus.ref_cnt_o, bus.sig_cnt_o} !== 68'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gate=%b busy=%b done=%b err=%b ref=%0d sig=%0d expected all 0",
                     bus.gate_o, bus.busy_o, bus.done_o, bus.err_o, bus.ref_cnt_o, bus.sig_cnt_o);
        end
        rst_i = 1'b0;
        bus.sig_i = 1'b0;
        bus.tick_i = 1'b0;
        bus.gate_st_i = 1'b1;
        bus.gate_time_i = 8'd1;
        @(posedge clk_i); #1;
        bus.gate_st_i = 1'b0;
        n_tests++;
        if (bus.busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL first_start: busy got %b expected 1", bus.busy_o);
        end
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    task automatic test_normal();
        int nd, di, gs, dk, rc, sc;
        bit err;
        clear_stim();
        for (int k = 1; k < NMAX; k++) begin
            tick_a[k] = (k % 10) == 1;
            sig_a[k]  = (k % 4) >= 2;
        end
        model(2, 200, gs, dk, err, rc, sc);
        run_cycles(8'd2, 100);
        nd = 0; di = 0;
        for (int k = 0; k < 100; k++) if (ob_done[k]) begin nd++; di = k; end
        n_tests++;
        if (nd !== 1) begin n_fail++; $display("FAIL normal_done_count: got %0d expected 1", nd); end
        n_tests++;
        if (ob_err[di] !== 1'b0) begin n_fail++; $display("FAIL normal_err: got %b expected 0", ob_err[di]); end
        n_tests++;
        if (!(ob_sig[di] >= 5)) begin n_fail++; $display("FAIL normal_sig_min: got %0d expected >=5", ob_sig[di]); end
        n_tests++;
        if (ob_ref[di] !== 4 * ob_sig[di]) begin
            n_fail++; $display("FAIL normal_ratio: ref got %0d expected %0d", ob_ref[di], 4 * ob_sig[di]);
        end
        n_tests++;
        if (ob_ref[di] !== 32'(rc) || ob_sig[di] !== 32'(sc) || di !== dk) begin
            n_fail++;
            $display("FAIL normal_model: got ref=%0d sig=%0d done@%0d expected ref=%0d sig=%0d done@%0d",
                     ob_ref[di], ob_sig[di], di, rc, sc, dk);
        end
    endtask

    task automatic test_timeout_arm();
        int nd, di;
        bit any_gate;
        clear_stim();
        for (int k = 1; k < NMAX; k++) tick_a[k] = (k % 10) == 5;
        run_cycles(8'd3, 40);
        nd = 0; di = 0; any_gate = 0;
        for (int k = 0; k < 40; k++) begin
            if (ob_done[k]) begin nd++; di = k; end
            if (ob_gate[k]) any_gate = 1;
        end
        n_tests++;
        if (nd !== 1 || di !== 25) begin
            n_fail++; $display("FAIL arm_timeout_done: got %0d pulses at %0d expected 1 at 25", nd, di);
        end
        n_tests++;
        if (ob_err[di] !== 1'b1 || ob_ref[di] !== 32'd0 || ob_sig[di] !== 32'd0) begin
            n_fail++;
            $display("FAIL arm_timeout_result: got err=%b ref=%0d sig=%0d expected err=1 ref=0 sig=0",
                     ob_err[di], ob_ref[di], ob_sig[di]);
        end
        n_tests++;
        if (any_gate !== 1'b0) begin n_fail++; $display("FAIL arm_timeout_gate: gate got 1 expected never"); end
    endtask

    task automatic test_zero_and_busy();
        int nd, di;
        bit any_busy;
        clear_stim();
        for (int k = 1; k < NMAX; k++) begin
            tick_a[k] = (k % 10) == 5;
            sig_a[k]  = bit'($urandom_range(0, 1));
        end
        run_cycles(8'd0, 40);
        nd = 0; any_busy = 0;
        for (int k = 0; k < 40; k++) begin
            if (ob_done[k]) nd++;
            if (ob_busy[k]) any_busy = 1;
        end
        n_tests++;
        if (nd !== 0 || any_busy !== 1'b0) begin
            n_fail++; $display("FAIL zero_gate: got done=%0d busy_seen=%b expected 0 and 0", nd, any_busy);
        end
        clear_stim();
        for (int k = 1; k < NMAX; k++) tick_a[k] = (k % 10) == 5;
        st_a[3] = 1'b1;
        gtx_a[3] = 8'd9;
        run_cycles(8'd2, 40);
        nd = 0; di = 0;
        for (int k = 0; k < 40; k++) if (ob_done[k]) begin nd++; di = k; end
        n_tests++;
        if (nd !== 1 || di !== 15 || ob_err[di] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_start: got %0d pulses at %0d err=%b expected 1 at 15 err=1", nd, di, ob_err[di]);
        end
    endtask

    task automatic test_simultaneous();
        int nd, di;
        clear_stim();
        sig_a[3] = 1; sig_a[4] = 1;
        sig_a[8] = 1; sig_a[9] = 1;
        sig_a[14] = 1; sig_a[15] = 1;
        tick_a[8] = 1;
        run_cycles(8'd1, 30);
        n_tests++;
        if (ob_gate[9] !== 1'b1 || ob_done[9] !== 1'b0 || ob_sig[8] !== 32'd1) begin
            n_fail++;
            $display("FAIL simul_close_state: got gate=%b done=%b sig=%0d expected gate=1 done=0 sig=1",
                     ob_gate[9], ob_done[9], ob_sig[8]);
        end
        nd = 0; di = 0;
        for (int k = 0; k < 30; k++) if (ob_done[k]) begin nd++; di = k; end
        n_tests++;
        if (nd !== 1 || di !== 14) begin
            n_fail++; $display("FAIL simul_done: got %0d pulses at %0d expected 1 at 14", nd, di);
        end
        n_tests++;
        if (ob_sig[di] !== 32'd2 || ob_ref[di] !== 32'd11 || ob_err[di] !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_counts: got sig=%0d ref=%0d err=%b expected sig=2 ref=11 err=0",
                     ob_sig[di], ob_ref[di], ob_err[di]);
        end
    endtask

    task automatic test_reset_mid();
        int nd, di;
        bit seen_done;
        clear_stim();
        for (int k = 1; k < NMAX; k++) begin
            tick_a[k] = (k % 10) == 1;
            sig_a[k]  = (k % 4) >= 2;
        end
        run_cycles(8'd3, 8);
        n_tests++;
        if (ob_gate[7] !== 1'b1) begin n_fail++; $display("FAIL rmid_open: gate got %b expected 1", ob_gate[7]); end
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        n_tests++;
        if ({bus.gate_o, bus.busy_o, bus.done_o, bus.err_o, bus.ref_cnt_o, bus.sig_cnt_o} !== 68'd0) begin
            n_fail++;
            $display("FAIL rmid_clear: got gate=%b busy=%b done=%b err=%b ref=%0d sig=%0d expected all 0",
                     bus.gate_o, bus.busy_o, bus.done_o, bus.err_o, bus.ref_cnt_o, bus.sig_cnt_o);
        end
        seen_done = 0;
        for (int j = 0; j < 5; j++) begin
            bus.sig_i = j[0];
            @(posedge clk_i); #1;
            if (bus.done_o) seen_done = 1;
        end
        n_tests++;
        if (seen_done !== 1'b0) begin n_fail++; $display("FAIL rmid_no_done: done got 1 expected 0"); end
        run_cycles(8'd2, 60);
        nd = 0; di = 0;
        for (int k = 0; k < 60; k++) if (ob_done[k]) begin nd++; di = k; end
        n_tests++;
        if (nd !== 1 || ob_err[di] !== 1'b0 || ob_ref[di] !== 32'd20 || ob_sig[di] !== 32'd5) begin
            n_fail++;
            $display("FAIL rmid_restart: got done=%0d err=%b ref=%0d sig=%0d expected 1 0 20 5",
                     nd, ob_err[di], ob_ref[di], ob_sig[di]);
        end
    endtask

    task automatic test_saturation();
        bit wrapped;
        clear_stim();
        for (int k = 1; k < 10; k++) begin
            tick_a[k] = (k % 10) == 1;
            sig_a[k]  = (k % 4) >= 2;
        end
        run_cycles(8'd5, 10);
        n_tests++;
        if (ob_gate[9] !== 1'b1) begin n_fail++; $display("FAIL sat_open: gate got %b expected 1", ob_gate[9]); end
        force dut.r_ref_cnt = 32'hFFFF_FFFD;
        force dut.r_sig_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_ref_cnt;
        release dut.r_sig_cnt;
        wrapped = 0;
        for (int j = 0; j < 8; j++) begin
            bus.sig_i = ((10 + j) % 4) >= 2;
            bus.tick_i = 1'b0;
            @(posedge clk_i); #1;
            if (bus.ref_cnt_o == 32'd0 || bus.sig_cnt_o == 32'd0) wrapped = 1;
        end
        n_tests++;
        if (bus.ref_cnt_o !== 32'hFFFF_FFFF || wrapped !== 1'b0) begin
            n_fail++; $display("FAIL sat_ref: got %h wrapped=%b expected ffffffff no wrap", bus.ref_cnt_o, wrapped);
        end
        n_tests++;
        if (bus.sig_cnt_o !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL sat_sig: got %h expected ffffffff", bus.sig_cnt_o);
        end
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            int gt, per, ph, mode, sp, gs, dk, rc, sc, bad_k;
            bit err;
            clear_stim();
            gt = $urandom_range(1, 4);
            per = $urandom_range(3, 12);
            ph = $urandom_range(0, per - 1);
            mode = $urandom_range(0, 3);
            sp = $urandom_range(2, 10);
            for (int k = 1; k < NMAX; k++) begin
                tick_a[k] = (k % per) == ph;
                if (mode == 1) sig_a[k] = bit'($urandom_range(0, 1));
                else if (mode == 2) sig_a[k] = ($urandom_range(0, 9) == 0) ? !sig_a[k-1] : sig_a[k-1];
                else if (mode == 3) sig_a[k] = (k % sp) < (sp / 2);
                st_a[k] = $urandom_range(0, 15) == 0;
                gtx_a[k] = 8'($urandom_range(0, 255));
            end
            model(gt, 400, gs, dk, err, rc, sc);
            n_tests++;
            if (dk < 0) begin
                n_fail++; $display("FAIL rand_bound: iter %0d no completion predicted", it);
                continue;
            end
            for (int k = dk + 1; k < NMAX; k++) st_a[k] = 1'b0;
            run_cycles(8'(gt), dk + 3);
            bad_k = -1;
            for (int k = 0; k < dk + 3; k++) begin
                if (bad_k < 0 && (ob_busy[k] !== (k <= dk) || ob_done[k] !== (k == dk) ||
                    ob_gate[k] !== (gs >= 0 && k >= gs && k < dk))) bad_k = k;
            end
            n_tests++;
            if (bad_k >= 0) begin
                n_fail++;
                $display("FAIL rand_wave: iter %0d cycle %0d got gate=%b busy=%b done=%b expected gate=%b busy=%b done=%b",
                         it, bad_k, ob_gate[bad_k], ob_busy[bad_k], ob_done[bad_k],
                         gs >= 0 && bad_k >= gs && bad_k < dk, bad_k <= dk, bad_k == dk);
            end
            n_tests++;
            if (ob_ref[dk] !== 32'(rc) || ob_sig[dk] !== 32'(sc) || ob_err[dk] !== err) begin
                n_fail++;
                $display("FAIL rand_result: iter %0d got ref=%0d sig=%0d err=%b expected ref=%0d sig=%0d err=%b",
                         it, ob_ref[dk], ob_sig[dk], ob_err[dk], rc, sc, err);
            end
            n_tests++;
            if (ob_ref[dk+2] !== 32'(rc) || ob_sig[dk+2] !== 32'(sc) || ob_err[dk+2] !== err) begin
                n_fail++;
                $display("FAIL rand_hold: iter %0d got ref=%0d sig=%0d err=%b expected ref=%0d sig=%0d err=%b",
                         it, ob_ref[dk+2], ob_sig[dk+2], ob_err[dk+2], rc, sc, err);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.gate_st_i = 1'b0;
        bus.gate_time_i = 8'd0;
        bus.tick_i = 1'b0;
        bus.sig_i = 1'b0;
        test_reset();
        test_normal();
        test_timeout_arm();
        test_zero_and_busy();
        test_simultaneous();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
